// File: rtl/dbg_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbg_bus_pkg : command/status codes and parser states for dbg_bus_master
// Rev 1.0
// ---------------------------------------------------------------------------
package dbg_bus_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] STS_ACK   = 8'h06;
   localparam logic [7:0] STS_NAK   = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_BUS  = 3'd3,
      ST_RESP = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/dbg_tx_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbg_tx_serializer : streams a status byte, optionally followed by a
// little-endian 32-bit word, over a valid/ready byte interface
// Rev 1.0
// ---------------------------------------------------------------------------
module dbg_tx_serializer
   import dbg_bus_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load_i,
   input  logic [7:0]  status_i,
   input  logic [31:0] word_i,
   input  logic        with_word_i,
   input  logic        tx_ready_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   output logic        last_o
);

   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic [31:0] shift_q;
   logic [2:0]  rem_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         shift_q    <= 32'h0;
         rem_q      <= 3'd0;
      end else if (load_i) begin
         tx_valid_q <= 1'b1;
         tx_data_q  <= status_i;
         shift_q    <= word_i;
         rem_q      <= with_word_i ? 3'd4 : 3'd0;
      end else if (tx_valid_q && tx_ready_i) begin
         // keep tx_valid up between bytes so the word streams without gaps
         if (rem_q != 3'd0) begin
            tx_data_q <= shift_q[7:0];
            shift_q   <= {8'h00, shift_q[31:8]};
            rem_q     <= rem_q - 3'd1;
         end else begin
            tx_valid_q <= 1'b0;
         end
      end
   end

   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign last_o     = tx_valid_q && tx_ready_i && (rem_q == 3'd0);

endmodule
`default_nettype wire

// File: rtl/dbg_bus_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbg_bus_master : UART byte-stream command parser driving single-word
// transactions on a picorv32-style native memory bus
// Rev 1.0
// ---------------------------------------------------------------------------
module dbg_bus_master
   import dbg_bus_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT   = 1024,
   parameter int unsigned FRAME_TIMEOUT = 50_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned BW = $clog2(BUS_TIMEOUT + 1);
   localparam int unsigned FW = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [BW-1:0] BUS_LAST   = BW'(BUS_TIMEOUT - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          is_write_q, is_write_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [FW-1:0] ftmr_q, ftmr_d;
   logic [BW-1:0] btmr_q, btmr_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          mem_valid_q, mem_valid_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_wstrb_q, mem_wstrb_d;
   logic          overrun_q, overrun_d;
   logic          busy_q;

   logic          ser_load;
   logic [7:0]    ser_status;
   logic          ser_with_word;
   logic          ser_last;

   always_comb begin
      state_d       = state_q;
      is_write_d    = is_write_q;
      cnt_d         = cnt_q;
      ftmr_d        = ftmr_q;
      btmr_d        = btmr_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      mem_valid_d   = mem_valid_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_wstrb_d   = mem_wstrb_q;
      overrun_d     = overrun_q;
      ser_load      = 1'b0;
      ser_status    = STS_ACK;
      ser_with_word = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
               is_write_d = (rx_data == CMD_WRITE);
               cnt_d      = 2'd0;
               ftmr_d     = '0;
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR, ST_DATA: begin
            // an arriving byte beats a simultaneous frame-timer expiry
            if (rx_valid) begin
               ftmr_d = '0;
               cnt_d  = cnt_q + 2'd1;
               if (state_q == ST_ADDR) addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
               else                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
               if (cnt_q == 2'd3) begin
                  if (state_q == ST_ADDR && is_write_q) begin
                     state_d = ST_DATA;
                  end else begin
                     state_d     = ST_BUS;
                     btmr_d      = '0;
                     mem_valid_d = 1'b1;
                     mem_addr_d  = {addr_d[31:2], 2'b00};
                     mem_wdata_d = is_write_q ? wdata_d : 32'h0;
                     mem_wstrb_d = is_write_q ? 4'hF : 4'h0;
                  end
               end
            end else if (ftmr_q == FRAME_LAST) begin
               state_d = ST_IDLE;
            end else begin
               ftmr_d = ftmr_q + 1'b1;
            end
         end
         ST_BUS: begin
            if (mem_ready) begin
               mem_valid_d   = 1'b0;
               ser_load      = 1'b1;
               ser_status    = STS_ACK;
               ser_with_word = !is_write_q;
               state_d       = ST_RESP;
            end else if (btmr_q == BUS_LAST) begin
               mem_valid_d = 1'b0;
               ser_load    = 1'b1;
               ser_status  = STS_NAK;
               state_d     = ST_RESP;
            end else begin
               btmr_d = btmr_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (ser_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (rx_valid && (state_q == ST_BUS || state_q == ST_RESP)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         is_write_q  <= 1'b0;
         cnt_q       <= 2'd0;
         ftmr_q      <= '0;
         btmr_q      <= '0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'h0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         cnt_q       <= cnt_d;
         ftmr_q      <= ftmr_d;
         btmr_q      <= btmr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         overrun_q   <= overrun_d;
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   dbg_tx_serializer u_ser (
      .clk         (clk),
      .resetn      (resetn),
      .load_i      (ser_load),
      .status_i    (ser_status),
      .word_i      (mem_rdata),
      .with_word_i (ser_with_word),
      .tx_ready_i  (tx_ready),
      .tx_valid_o  (tx_valid),
      .tx_data_o   (tx_data),
      .last_o      (ser_last)
   );

   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire
